// File: rtl/encounter_scheduler.sv
// encounter_scheduler: spawns, scrolls and animates four obstacle slots
// for the runner game; freezes on collision until the next start pulse.
module encounter_scheduler #(
    parameter int unsigned SPAWN_X     = 1500,
    parameter int unsigned SPEED_INIT  = 6,
    parameter int unsigned SPEED_MAX   = 14,
    parameter int unsigned MIN_GAP     = 30,
    parameter int unsigned ANIM_DIV    = 20000000,
    parameter int unsigned ANIM_FRAMES = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] display_col,
    input  logic [10:0] display_row,
    input  logic        start,
    input  logic        hit,
    output logic [3:0]  slot_active,
    output logic [47:0] slot_x,
    output logic [2:0]  anim_frame,
    output logic [4:0]  speed,
    output logic [15:0] spawn_count,
    output logic        game_over
);
    localparam int unsigned AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, FREEZE} state_t;

    state_t state, state_next;
    logic enter_play;

    logic origin, origin_q, frame_tick;
    logic [15:0] lfsr;
    logic lfsr_fb;
    logic [7:0] gap_cnt, gap_target, gap_inc;
    logic [AW-1:0] anim_cnt;
    logic [3:0] active;
    logic [3:0][11:0] xpos;
    logic [1:0] free_idx;
    logic free_any, do_spawn, speed_up;
    logic [15:0] count_inc;

    assign origin      = (display_col == 12'd0) && (display_row == 11'd0);
    assign lfsr_fb     = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign slot_active = active;
    assign slot_x      = xpos;

    always_comb begin
        state_next = state;
        enter_play = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = PLAY;
                    enter_play = 1'b1;
                end
            end
            PLAY: begin
                if (hit) begin
                    state_next = FREEZE;
                end else if (start) begin
                    enter_play = 1'b1;
                end
            end
            FREEZE: begin
                if (start) begin
                    state_next = PLAY;
                    enter_play = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lowest-index free slot, judged on occupancy before this tick's expiries.
    always_comb begin
        free_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!active[i]) free_idx = 2'(i);
        end
    end

    assign free_any  = ~&active;
    assign gap_inc   = (gap_cnt == 8'hFF) ? gap_cnt : gap_cnt + 8'd1;
    assign do_spawn  = free_any && (gap_inc >= gap_target);
    assign count_inc = (spawn_count == 16'hFFFF) ? spawn_count
                                                 : spawn_count + 16'd1;
    assign speed_up  = (count_inc != spawn_count) && (count_inc[3:0] == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            origin_q    <= 1'b0;
            frame_tick  <= 1'b0;
            lfsr        <= 16'hACE1;
            active      <= '0;
            xpos        <= '0;
            anim_cnt    <= '0;
            anim_frame  <= 3'd0;
            speed       <= 5'(SPEED_INIT);
            spawn_count <= 16'd0;
            gap_cnt     <= 8'd0;
            gap_target  <= 8'(MIN_GAP);
            game_over   <= 1'b0;
        end else begin
            origin_q   <= origin;
            frame_tick <= origin && !origin_q;
            lfsr       <= {lfsr_fb, lfsr[15:1]};
            if (enter_play) begin
                active      <= '0;
                xpos        <= '0;
                anim_cnt    <= '0;
                anim_frame  <= 3'd0;
                speed       <= 5'(SPEED_INIT);
                spawn_count <= 16'd0;
                gap_cnt     <= 8'd0;
                gap_target  <= 8'(MIN_GAP);
                game_over   <= 1'b0;
            end else if (state == PLAY && hit) begin
                game_over <= 1'b1;
            end else if (state == PLAY) begin
                if (anim_cnt == AW'(ANIM_DIV - 1)) begin
                    anim_cnt   <= '0;
                    anim_frame <= (anim_frame == 3'(ANIM_FRAMES - 1))
                                  ? 3'd0 : anim_frame + 3'd1;
                end else begin
                    anim_cnt <= anim_cnt + AW'(1);
                end
                if (frame_tick) begin
                    gap_cnt <= gap_inc;
                    for (int i = 0; i < 4; i++) begin
                        if (active[i]) begin
                            if (xpos[i] <= {7'd0, speed}) begin
                                active[i] <= 1'b0;
                                xpos[i]   <= 12'd0;
                            end else begin
                                xpos[i] <= xpos[i] - {7'd0, speed};
                            end
                        end
                    end
                    // The spawned slot was free, so no move above touches it.
                    if (do_spawn) begin
                        active[free_idx] <= 1'b1;
                        xpos[free_idx]   <= 12'(SPAWN_X);
                        gap_cnt          <= 8'd0;
                        gap_target       <= 8'(MIN_GAP) + {3'd0, lfsr[4:0]};
                        spawn_count      <= count_inc;
                        if (speed_up && speed < 5'(SPEED_MAX)) begin
                            speed <= speed + 5'd1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_encounter_scheduler.sv
// Bench for encounter_scheduler: random raster/hit/start stimulus checked
// every clock against a slot-level reference model.
module tb_encounter_scheduler;
    localparam int ADIV = 4;
    localparam int AFRM = 6;

    logic        clock;
    logic        reset;
    logic [11:0] display_col;
    logic [10:0] display_row;
    logic        start;
    logic        hit;
    logic [3:0]  slot_active;
    logic [47:0] slot_x;
    logic [2:0]  anim_frame;
    logic [4:0]  speed;
    logic [15:0] spawn_count;
    logic        game_over;

    encounter_scheduler #(
        .SPAWN_X(1500), .SPEED_INIT(6), .SPEED_MAX(14), .MIN_GAP(30),
        .ANIM_DIV(ADIV), .ANIM_FRAMES(AFRM)
    ) dut (
        .clock(clock), .reset(reset),
        .display_col(display_col), .display_row(display_row),
        .start(start), .hit(hit),
        .slot_active(slot_active), .slot_x(slot_x),
        .anim_frame(anim_frame), .speed(speed),
        .spawn_count(spawn_count), .game_over(game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: run/frozen flags, per-slot arrays, plain integers.
    bit m_playing, m_frozen, m_over, m_origin_q, m_tick;
    bit m_act [4];
    int m_x [4];
    int m_lfsr, m_anim, m_frame, m_speed, m_count, m_gap, m_target;
    int play_ticks;

    task automatic check(input string tag, input logic [79:0] got,
                         input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_init();
        m_playing = 1; m_frozen = 0; m_over = 0;
        for (int i = 0; i < 4; i++) begin m_act[i] = 0; m_x[i] = 0; end
        m_speed = 6; m_count = 0; m_gap = 0; m_target = 30;
        m_anim = 0; m_frame = 0; play_ticks = 0;
    endtask

    task automatic model_step();
        bit org, tick, spawn;
        int lf, fb, free;
        if (reset) begin
            m_init();
            m_playing = 0; m_origin_q = 0; m_tick = 0; m_lfsr = 'hACE1;
            return;
        end
        org  = (display_col == 0) && (display_row == 0);
        tick = m_tick;
        lf   = m_lfsr;
        m_tick = org && !m_origin_q;
        m_origin_q = org;
        fb = (lf ^ (lf >> 2) ^ (lf >> 3) ^ (lf >> 5)) & 1;
        m_lfsr = (lf >> 1) | (fb << 15);
        if (!m_playing) begin
            if (start) m_init();
        end else if (hit) begin
            m_playing = 0; m_frozen = 1; m_over = 1;
        end else if (start) begin
            m_init();
        end else begin
            m_anim++;
            if (m_anim == ADIV) begin
                m_anim = 0;
                m_frame = (m_frame + 1) % AFRM;
            end
            if (tick) begin
                play_ticks++;
                free = -1;
                for (int i = 3; i >= 0; i--) if (!m_act[i]) free = i;
                m_gap = (m_gap < 255) ? m_gap + 1 : 255;
                spawn = (m_gap >= m_target) && (free >= 0);
                for (int i = 0; i < 4; i++) begin
                    if (m_act[i]) begin
                        if (m_x[i] <= m_speed) begin m_act[i] = 0; m_x[i] = 0; end
                        else m_x[i] -= m_speed;
                    end
                end
                if (spawn) begin
                    m_act[free] = 1; m_x[free] = 1500;
                    m_gap = 0; m_target = 30 + (lf & 31);
                    if (m_count < 65535) begin
                        m_count++;
                        if (m_count % 16 == 0 && m_speed < 14) m_speed++;
                    end
                end
            end
        end
    endtask

    function automatic logic [79:0] exp_vec();
        logic [47:0] xs;
        logic [3:0]  a;
        for (int i = 0; i < 4; i++) begin
            xs[12*i +: 12] = 12'(m_x[i]);
            a[i] = m_act[i];
        end
        return {3'b0, a, xs, 3'(m_frame), 5'(m_speed), 16'(m_count), m_over};
    endfunction

    task automatic cycle(input logic r, input logic s, input logic h,
                         input logic [11:0] c, input logic [10:0] w);
        reset = r; start = s; hit = h; display_col = c; display_row = w;
        @(posedge clock);
        model_step();
        cyc++;
        #1;
        check("outputs", {3'b0, slot_active, slot_x, anim_frame, speed,
                          spawn_count, game_over}, exp_vec());
    endtask

    task automatic frame(input int hold, input int rest, input bit rnd);
        logic r, s, h;
        for (int k = 0; k < hold + rest; k++) begin
            r = 0; s = 0; h = 0;
            if (rnd) begin
                r = ($urandom % 500) == 0;
                s = ($urandom % 150) == 0;
                h = ($urandom % 200) == 0;
            end
            if (k < hold) cycle(r, s, h, 12'd0, 11'd0);
            else cycle(r, s, h, 12'(1 + $urandom % 639), 11'($urandom % 480));
        end
    endtask

    int saved;

    initial begin
        reset = 1; start = 0; hit = 0; display_col = 12'd5; display_row = 11'd5;
        m_origin_q = 0; m_tick = 0; m_lfsr = 'hACE1; m_init(); m_playing = 0;

        cycle(1, 0, 0, 12'd5, 11'd5);
        cycle(1, 0, 0, 12'd5, 11'd5);
        check("rst_active", 80'(slot_active), 80'(0));
        check("rst_x", 80'(slot_x), 80'(0));
        check("rst_speed", 80'(speed), 80'(6));
        check("rst_count", 80'(spawn_count), 80'(0));
        check("rst_over", 80'(game_over), 80'(0));
        check("rst_lfsr", 80'(dut.lfsr), 80'(16'hACE1));

        cycle(0, 1, 0, 12'd5, 11'd5);
        while (play_ticks < 29 && cyc < 1000) frame(1, 3, 0);
        check("pre_spawn", 80'(slot_active), 80'(0));
        while (play_ticks < 30 && cyc < 1000) frame(1, 3, 0);
        check("spawn30_act", 80'(slot_active), 80'(4'b0001));
        check("spawn30_x", 80'(slot_x[11:0]), 80'(1500));
        while (play_ticks < 35 && cyc < 1000) frame(3, 2, 0);
        check("move5_x", 80'(slot_x[11:0]), 80'(1470));

        cycle(0, 0, 0, 12'd0, 11'd0);
        saved = m_x[0];
        cycle(0, 0, 1, 12'd9, 11'd9);
        check("hit_over", 80'(game_over), 80'(1));
        check("hit_nomove", 80'(slot_x[11:0]), 80'(saved));
        for (int k = 0; k < 10; k++) cycle(0, 0, 1, 12'(k % 2), 11'd0);
        check("frozen_x", 80'(slot_x[11:0]), 80'(saved));
        cycle(0, 1, 1, 12'd9, 11'd9);
        check("restart_over", 80'(game_over), 80'(0));
        check("restart_act", 80'(slot_active), 80'(0));
        check("restart_speed", 80'(speed), 80'(6));
        cycle(0, 0, 1, 12'd9, 11'd9);
        check("rehit_over", 80'(game_over), 80'(1));

        cycle(0, 1, 0, 12'd9, 11'd9);
        begin
            bit seen16 = 0;
            while (m_count < 144 && cyc < 70000) begin
                frame($urandom_range(1, 3), $urandom_range(1, 2), 0);
                if (!seen16 && m_count >= 16 && m_count < 32) begin
                    seen16 = 1;
                    check("speed16", 80'(speed), 80'(7));
                end
            end
        end
        check("ramp_reached", 80'(m_count >= 144), 80'(1));
        check("count144", 80'(spawn_count), 80'(144));
        check("speed_max", 80'(speed), 80'(14));

        cycle(0, 1, 0, 12'd9, 11'd9);
        for (int f = 0; f < 1200; f++)
            frame($urandom_range(1, 3), $urandom_range(1, 3), 1);

        cycle(0, 1, 0, 12'd9, 11'd9);
        for (int k = 0; k < 6; k++) cycle(0, 0, 0, 12'd9, 11'd9);
        check("anim_mid", 80'(anim_frame), 80'(1));
        cycle(1, 0, 0, 12'd9, 11'd9);
        check("anim_reset", 80'(anim_frame), 80'(0));
        check("reset_speed", 80'(speed), 80'(6));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
